// File: rtl/divider_seq_param_pkg.sv
// Shared definitions for the parametrised sequential divider:
// FSM state encoding and the iteration-counter width helper.
package divider_seq_param_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Counter must be able to hold the value DW itself, hence DW+1.
    function automatic int cntWidth(input int dw);
        return $clog2(dw + 1);
    endfunction

endpackage

// File: rtl/divider_seq_param_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, compare against the divisor and subtract if it fits.
module divider_seq_param_step
    import divider_seq_param_pkg::*;
#(
    parameter int VW = 16
) (
    input  logic [VW-1:0] rem_i,
    input  logic          qMsb_i,
    input  logic [VW-1:0] div_i,
    output logic [VW-1:0] remNext_o,
    output logic          qBit_o
);

    logic [VW:0] trial;
    logic [VW:0] diff;

    // The trial value is one bit wider than the divisor so the compare and
    // subtract never overflow; after a successful subtract the result is
    // below the divisor and fits back into VW bits.
    always_comb begin
        trial     = {rem_i, qMsb_i};
        diff      = trial - {1'b0, div_i};
        qBit_o    = 1'b0;
        remNext_o = trial[VW-1:0];
        if (trial >= {1'b0, div_i}) begin
            qBit_o    = 1'b1;
            remNext_o = diff[VW-1:0];
        end
    end

endmodule

// File: rtl/divider_seq_param.sv
// Parametrised multi-cycle unsigned divider with start/ready handshake,
// single-cycle done pulse and divide-by-zero flag.
module divider_seq_param
    import divider_seq_param_pkg::*;
#(
    parameter int DW = 32,
    parameter int VW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic [DW-1:0] quotient,
    output logic [VW-1:0] remainder,
    output logic          ready,
    output logic          done,
    output logic          div_by_zero
);

    localparam int CW = cntWidth(DW);

    state_e        state_q,     state_d;
    logic [DW-1:0] shift_q,     shift_d;
    logic [VW-1:0] divReg_q,    divReg_d;
    logic [VW-1:0] partRem_q,   partRem_d;
    logic [CW-1:0] count_q,     count_d;
    logic [DW-1:0] quotient_q,  quotient_d;
    logic [VW-1:0] remainder_q, remainder_d;
    logic          divByZero_q, divByZero_d;

    logic [VW-1:0] remNext;
    logic          qBit;

    divider_seq_param_step #(.VW(VW)) uStep (
        .rem_i     (partRem_q),
        .qMsb_i    (shift_q[DW-1]),
        .div_i     (divReg_q),
        .remNext_o (remNext),
        .qBit_o    (qBit)
    );

    // State and datapath registers; active-low reset aborts any operation.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            divReg_q    <= '0;
            partRem_q   <= '0;
            count_q     <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            divByZero_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            divReg_q    <= divReg_d;
            partRem_q   <= partRem_d;
            count_q     <= count_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            divByZero_q <= divByZero_d;
        end
    end

    // Next-state logic. A zero divisor takes a single pass through RUN so
    // that done lands two edges after start; its results bypass the
    // iteration and come straight from the captured operands.
    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        divReg_d    = divReg_q;
        partRem_d   = partRem_q;
        count_d     = count_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        divByZero_d = divByZero_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    shift_d   = dividend;
                    divReg_d  = divisor;
                    partRem_d = '0;
                    count_d   = (divisor == '0) ? CW'(1) : CW'(DW);
                    state_d   = ST_RUN;
                end else begin
                    state_d   = ST_IDLE;
                end
            end
            ST_RUN: begin
                shift_d   = {shift_q[DW-2:0], qBit};
                partRem_d = remNext;
                count_d   = count_q - CW'(1);
                if (count_q == CW'(1)) begin
                    state_d = ST_DONE;
                    if (divReg_q == '0) begin
                        quotient_d  = '1;
                        remainder_d = shift_q[VW-1:0];
                        divByZero_d = 1'b1;
                    end else begin
                        quotient_d  = {shift_q[DW-2:0], qBit};
                        remainder_d = remNext;
                        divByZero_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = divByZero_q;
    assign ready       = (state_q != ST_RUN);
    assign done        = (state_q == ST_DONE);

endmodule

// File: tb/tb_divider_seq_param.sv
// Bench for divider_seq_param: arithmetic reference model plus directed tests.
module tb_divider_seq_param;

   localparam int DW = 32;
   localparam int VW = 16;

   logic          clk;
   logic          rst;
   logic          start;
   logic [DW-1:0] dividend;
   logic [VW-1:0] divisor;
   logic [DW-1:0] quotient;
   logic [VW-1:0] remainder;
   logic          ready;
   logic          done;
   logic          div_by_zero;

   int checks = 0;
   int errors = 0;
   int doneCount = 0;
   logic checkEn = 1'b0;

   // Reference model state: results from plain / and %, plus a latency timer.
   int            remaining = 0;
   logic          expDone = 1'b0;
   logic [DW-1:0] expQuot = '0;
   logic [VW-1:0] expRem = '0;
   logic          expDbz = 1'b0;
   logic [DW-1:0] pendQuot = '0;
   logic [VW-1:0] pendRem = '0;
   logic          pendDbz = 1'b0;

   divider_seq_param #(.DW(DW), .VW(VW)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .dividend    (dividend),
      .divisor     (divisor),
      .quotient    (quotient),
      .remainder   (remainder),
      .ready       (ready),
      .done        (done),
      .div_by_zero (div_by_zero)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: an accepted start schedules the answer DW edges later (one edge
   // for a zero divisor); starts arriving while busy are dropped.
   always @(posedge clk) begin
      if (!rst) begin
         remaining <= 0;
         expDone   <= 1'b0;
         expQuot   <= '0;
         expRem    <= '0;
         expDbz    <= 1'b0;
      end else if (remaining > 0) begin
         remaining <= remaining - 1;
         expDone   <= (remaining == 1);
         if (remaining == 1) begin
            expQuot <= pendQuot;
            expRem  <= pendRem;
            expDbz  <= pendDbz;
         end
      end else begin
         expDone <= 1'b0;
         if (start) begin
            if (divisor == '0) begin
               pendQuot  <= '1;
               pendRem   <= dividend[VW-1:0];
               pendDbz   <= 1'b1;
               remaining <= 1;
            end else begin
               pendQuot  <= dividend / DW'(divisor);
               pendRem   <= VW'(dividend % DW'(divisor));
               pendDbz   <= 1'b0;
               remaining <= DW;
            end
         end
      end
   end

   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Compare DUT against the model on every falling edge once reset is applied.
   always @(negedge clk) begin
      if (checkEn) begin
         checkOutput("done",      64'(done),        64'(expDone));
         checkOutput("ready",     64'(ready),       64'(remaining == 0));
         checkOutput("quotient",  64'(quotient),    64'(expQuot));
         checkOutput("remainder", 64'(remainder),   64'(expRem));
         checkOutput("divByZero", 64'(div_by_zero), 64'(expDbz));
         if (done) doneCount++;
      end
   end

   task automatic applyStimulus(input logic [DW-1:0] a, input logic [VW-1:0] b);
      dividend = a;
      divisor  = b;
      start    = 1'b1;
   endtask

   task automatic waitDone(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!done && k < 100);
      if (!done) begin
         checks++;
         errors++;
         $display("[TB] FAIL doneTimeout actual=%0d required=done", k);
      end
   endtask

   task automatic runOp(input logic [DW-1:0] a, input logic [VW-1:0] b, output int k);
      applyStimulus(a, b);
      @(negedge clk);
      start = 1'b0;
      waitDone(k);
   endtask

   // Directed sequence with hand-computed expectations.
   initial begin
      int k;
      int k2;
      int base;
      rst = 1'b0;
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (2) @(negedge clk);
      checkEn = 1'b1;
      checkOutput("resetQuot",  64'(quotient), 64'd0);
      checkOutput("resetRem",   64'(remainder), 64'd0);
      checkOutput("resetReady", 64'(ready), 64'd1);
      checkOutput("resetDone",  64'(done), 64'd0);
      rst = 1'b1;
      @(negedge clk);

      runOp(32'd50, 16'd23, k);
      checkOutput("lat50",  64'(k), 64'd32);
      checkOutput("q50",    64'(quotient), 64'd2);
      checkOutput("r50",    64'(remainder), 64'd4);
      checkOutput("z50",    64'(div_by_zero), 64'd0);
      checkOutput("model50", 64'(expQuot), 64'd2);
      @(negedge clk);

      runOp(32'hFFFF_FFFF, 16'hFFFF, k);
      checkOutput("qMax", 64'(quotient), 64'h0001_0001);
      checkOutput("rMax", 64'(remainder), 64'd0);
      @(negedge clk);

      runOp(32'd5, 16'd7, k);
      checkOutput("qSmall", 64'(quotient), 64'd0);
      checkOutput("rSmall", 64'(remainder), 64'd5);
      @(negedge clk);

      runOp(32'h1234_ABCD, 16'd0, k);
      checkOutput("latZero", 64'(k), 64'd1);
      checkOutput("qZero",   64'(quotient), 64'hFFFF_FFFF);
      checkOutput("rZero",   64'(remainder), 64'hABCD);
      checkOutput("zZero",   64'(div_by_zero), 64'd1);
      checkOutput("modelZero", 64'(expRem), 64'hABCD);
      @(negedge clk);

      // Start pulsed while busy must be ignored.
      base = doneCount;
      applyStimulus(32'd1000, 16'd3);
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      applyStimulus(32'd77, 16'd5);
      @(negedge clk);
      start = 1'b0;
      dividend = '0;
      divisor = '0;
      repeat (40) @(negedge clk);
      checkOutput("busyDoneCount", 64'(doneCount - base), 64'd1);
      checkOutput("qBusy", 64'(quotient), 64'd333);
      checkOutput("rBusy", 64'(remainder), 64'd1);

      // Reset in the middle of an operation aborts it.
      base = doneCount;
      applyStimulus(32'd12345, 16'd11);
      @(negedge clk);
      start = 1'b0;
      repeat (14) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      checkOutput("abortQuot",  64'(quotient), 64'd0);
      checkOutput("abortRem",   64'(remainder), 64'd0);
      checkOutput("abortReady", 64'(ready), 64'd1);
      repeat (40) @(negedge clk);
      checkOutput("abortDoneCount", 64'(doneCount - base), 64'd0);
      runOp(32'd100, 16'd7, k);
      checkOutput("q100", 64'(quotient), 64'd14);
      checkOutput("r100", 64'(remainder), 64'd2);
      @(negedge clk);

      // Start held high: second operation accepted in the DONE cycle.
      base = doneCount;
      applyStimulus(32'd1000, 16'd10);
      waitDone(k);
      checkOutput("b2bLat1", 64'(k), 64'd33);
      checkOutput("q1000", 64'(quotient), 64'd100);
      checkOutput("r1000", 64'(remainder), 64'd0);
      dividend = 32'd999;
      waitDone(k2);
      start = 1'b0;
      checkOutput("b2bGap", 64'(k2), 64'd33);
      checkOutput("q999", 64'(quotient), 64'd99);
      checkOutput("r999", 64'(remainder), 64'd9);
      repeat (3) @(negedge clk);
      checkOutput("b2bDoneCount", 64'(doneCount - base), 64'd2);

      checkEn = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
